// File: rtl/i2s_pkg.sv
// Shared I2S constants and types for the capture deserializer and the playback serializer.
package i2s_pkg;

  localparam int I2S_DATA_W = 24;
  localparam int I2S_SLOT_W = 32;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } i2s_rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input; latency STAGES Clk, then a 1-Clk rise/fall pulse.
// No backpressure: the input is sampled every Clk.
module i2s_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync_q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  always_comb begin
    chain_d    = chain_q << 1;
    chain_d[0] = d;
    prev_d     = chain_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_q = chain_q[STAGES-1];
  assign rise   = sync_q & ~prev_q;
  assign fall   = ~sync_q & prev_q;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S capture: codec-mastered SCLK/LRCLK/ADCDAT to parallel L/R pairs; valid rises SYNC_STAGES+2 Clk after the right LSB rise.
// valid/ready output; an unaccepted pair is overwritten by the next one and flags overrun.
module i2s_rx_deserializer
  import i2s_pkg::*;
#(
  parameter int DATA_W      = I2S_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              SCLK,
  input  logic              LRCLK,
  input  logic              ADCDAT,
  input  logic              enable,
  output logic [DATA_W-1:0] sample_left,
  output logic [DATA_W-1:0] sample_right,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              frame_err,
  input  logic              clear_flags,
  output logic [7:0]        level
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic lrclk_s, lr_rise, lr_fall;
  logic adc_s, adc_rise, adc_fall;

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(Clk), .rst(Reset), .d(SCLK), .sync_q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrclk (
    .clk(Clk), .rst(Reset), .d(LRCLK), .sync_q(lrclk_s), .rise(lr_rise), .fall(lr_fall)
  );
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_adc (
    .clk(Clk), .rst(Reset), .d(ADCDAT), .sync_q(adc_s), .rise(adc_rise), .fall(adc_fall)
  );

  i2s_rx_state_t     state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              chan_q, chan_d;
  logic              lr_prev_q, lr_prev_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic              hold_l_vld_q, hold_l_vld_d;
  logic [DATA_W-1:0] sample_left_q, sample_left_d;
  logic [DATA_W-1:0] sample_right_q, sample_right_d;
  logic              sample_valid_q, sample_valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        level_q, level_d;

  logic              lr_chg;
  logic              pair_done;
  logic              frame_err_set;
  logic [DATA_W-1:0] neg_left, mag;
  logic [7:0]        cand;
  logic              unused_bits;

  // LRCLK is only meaningful at SCLK rises; lr_prev tracks its value at the previous rise.
  assign lr_chg = sclk_rise && (lrclk_s != lr_prev_q);

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    chan_d        = chan_q;
    shreg_d       = shreg_q;
    hold_l_d      = hold_l_q;
    hold_l_vld_d  = hold_l_vld_q;
    lr_prev_d     = sclk_rise ? lrclk_s : lr_prev_q;
    pair_done     = 1'b0;
    frame_err_set = 1'b0;
    if (!enable) begin
      state_d      = HUNT;
      bit_cnt_d    = '0;
      hold_l_vld_d = 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          if (lr_chg && lrclk_s == CH_LEFT) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            chan_d    = CH_LEFT;
          end
        end
        SHIFT: begin
          if (bit_cnt_q == CNT_W'(DATA_W)) begin
            state_d = WAIT;
            if (chan_q == CH_LEFT) begin
              hold_l_d     = shreg_q;
              hold_l_vld_d = 1'b1;
            end else begin
              pair_done    = hold_l_vld_q;
              hold_l_vld_d = 1'b0;
            end
          end else if (lr_chg) begin
            frame_err_set = 1'b1;
            bit_cnt_d     = '0;
            hold_l_vld_d  = 1'b0;
            if (lrclk_s == CH_LEFT) begin
              state_d = SHIFT;
              chan_d  = CH_LEFT;
            end else begin
              state_d = HUNT;
            end
          end else if (sclk_rise) begin
            shreg_d   = {shreg_q[DATA_W-2:0], adc_s};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        WAIT: begin
          if (lr_chg) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            chan_d    = lrclk_s ? CH_RIGHT : CH_LEFT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Saturating magnitude of the left sample; the most negative code maps to full scale.
  always_comb begin
    neg_left = -hold_l_q;
    if (!hold_l_q[DATA_W-1]) begin
      mag = hold_l_q;
    end else if (neg_left[DATA_W-1]) begin
      mag = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      mag = neg_left;
    end
    cand = mag[DATA_W-2 -: 8];
  end

  assign unused_bits = ^{sclk_s, sclk_fall, lr_rise, lr_fall, adc_rise, adc_fall,
                         mag[DATA_W-1], mag[DATA_W-10:0]};

  always_comb begin
    sample_left_d  = sample_left_q;
    sample_right_d = sample_right_q;
    sample_valid_d = sample_valid_q;
    overrun_d      = overrun_q;
    frame_err_d    = frame_err_q;
    level_d        = level_q;
    if (pair_done) begin
      sample_left_d  = hold_l_q;
      sample_right_d = shreg_q;
      sample_valid_d = 1'b1;
      if (sample_valid_q && !sample_ready) begin
        overrun_d = 1'b1;
      end
      if (cand > level_q) begin
        level_d = cand;
      end else if (level_q != 8'd0) begin
        level_d = level_q - 8'd1;
      end
    end else if (sample_valid_q && sample_ready) begin
      sample_valid_d = 1'b0;
    end
    if (frame_err_set) begin
      frame_err_d = 1'b1;
    end
    if (clear_flags) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= HUNT;
      bit_cnt_q      <= '0;
      chan_q         <= CH_LEFT;
      lr_prev_q      <= 1'b0;
      shreg_q        <= '0;
      hold_l_q       <= '0;
      hold_l_vld_q   <= 1'b0;
      sample_left_q  <= '0;
      sample_right_q <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      frame_err_q    <= 1'b0;
      level_q        <= 8'd0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      chan_q         <= chan_d;
      lr_prev_q      <= lr_prev_d;
      shreg_q        <= shreg_d;
      hold_l_q       <= hold_l_d;
      hold_l_vld_q   <= hold_l_vld_d;
      sample_left_q  <= sample_left_d;
      sample_right_q <= sample_right_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      frame_err_q    <= frame_err_d;
      level_q        <= level_d;
    end
  end

  assign sample_left  = sample_left_q;
  assign sample_right = sample_right_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign frame_err    = frame_err_q;
  assign level        = level_q;

endmodule
